viterbi_conv_encoder: RTL and testbench



---
 rtl/viterbi_pkg.sv | 27 ++
 rtl/viterbi_conv_encoder.sv | 139 +++++++++++++
 tb/tb_viterbi_conv_encoder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg
//   Definitions shared by the convolutional encoder and the Viterbi decoder
//   core, so both ends of the link always agree on the code.
//   - K_DEFAULT, G0_OCT_DEFAULT, G1_OCT_DEFAULT : default code (K=4, 17/13 octal)
//   - MAX_K          : largest supported constraint length
//   - enc_state_t    : encoder FSM state encoding (DATA, TAIL)
//   - conv_parity()  : parity of a shift-register window masked by a generator
package viterbi_pkg;

  localparam int K_DEFAULT      = 4;
  localparam int G0_OCT_DEFAULT = 'o17;
  localparam int G1_OCT_DEFAULT = 'o13;
  localparam int MAX_K          = 7;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_TAIL = 1'b1
  } enc_state_t;

  // Window and generator share the same bit order: the MSB of the (K-bit)
  // generator taps the current input bit. Narrower codes are zero-extended.
  function automatic logic conv_parity(input logic [MAX_K-1:0] window,
                                       input logic [MAX_K-1:0] gen);
    return ^(window & gen);
  endfunction

endpackage

// File: rtl/viterbi_conv_encoder.sv
// viterbi_conv_encoder
//   Rate-1/2 feed-forward convolutional encoder feeding the Viterbi decoder's
//   rx_sym port. Bits come in over a valid/ready handshake; each accepted bit
//   produces one 2-bit symbol in a single-entry output register. With TAIL_EN
//   set, every frame is flushed with K-1 zero bits whose symbols are flagged
//   by sym_tail so the decoder's force_state0 can be driven directly.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     information bit offered
//   in_ready     encoder takes in_bit this cycle
//   in_bit       information bit
//   in_last      in_bit is the last bit of the frame
//   sym_valid    output register holds a symbol
//   sym_ready    downstream accepts the symbol
//   sym          {G0 parity, G1 parity}
//   sym_tail     symbol was produced by a tail bit
//   sym_last     final symbol of the frame
module viterbi_conv_encoder
  import viterbi_pkg::*;
#(
  parameter int K       = K_DEFAULT,
  parameter int G0_OCT  = G0_OCT_DEFAULT,
  parameter int G1_OCT  = G1_OCT_DEFAULT,
  parameter bit TAIL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [1:0] sym,
  output logic       sym_tail,
  output logic       sym_last
);

  localparam int CW = $clog2(K);

  enc_state_t      state, next_state;
  logic [CW-1:0]   tail_cnt, next_cnt;
  logic [K-2:0]    shift_reg;
  logic [K-1:0]    window;

  logic            can_load;
  logic            accept;
  logic            tail_load;
  logic            load;
  logic            u;
  logic            tail_d;
  logic            last_d;
  logic            par0;
  logic            par1;

  // The output register may take a new symbol when it is empty or being
  // drained this cycle; in_ready therefore depends on sym_ready but never
  // on in_valid.
  assign can_load  = !sym_valid || sym_ready;
  assign in_ready  = (state == ST_DATA) && can_load;
  assign accept    = in_ready && in_valid;
  assign tail_load = (state == ST_TAIL) && can_load;
  assign load      = accept || tail_load;

  // shift_reg[K-2] is the most recent previous bit, so the window lines up
  // with the octal generator taps MSB-first.
  assign window = {u, shift_reg};
  assign par0   = conv_parity(MAX_K'(window), MAX_K'(G0_OCT));
  assign par1   = conv_parity(MAX_K'(window), MAX_K'(G1_OCT));

  // Next-state logic: chooses the encoder input bit and the flags that go
  // with the symbol being loaded, and walks the tail counter down.
  always_comb begin
    next_state = state;
    next_cnt   = tail_cnt;
    u          = 1'b0;
    tail_d     = 1'b0;
    last_d     = 1'b0;
    case (state)
      ST_DATA: begin
        u = in_bit;
        if (accept && in_last) begin
          if (TAIL_EN) begin
            next_state = ST_TAIL;
            next_cnt   = CW'(K - 1);
          end else begin
            // Without a tail the encoder state carries over into the next
            // frame; only the frame boundary is marked.
            last_d = 1'b1;
          end
        end
      end
      ST_TAIL: begin
        tail_d = 1'b1;
        if (tail_load) begin
          next_cnt = tail_cnt - CW'(1);
          if (tail_cnt == CW'(1)) begin
            next_state = ST_DATA;
            last_d     = 1'b1;
          end
        end
      end
      default: next_state = ST_DATA;
    endcase
  end

  // State register and tail counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_DATA;
      tail_cnt <= '0;
    end else begin
      state    <= next_state;
      tail_cnt <= next_cnt;
    end
  end

  // Shift register and single-entry output register. Contents only change
  // on a load, so they stay stable while the symbol is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      sym_valid <= 1'b0;
      sym       <= 2'b00;
      sym_tail  <= 1'b0;
      sym_last  <= 1'b0;
    end else if (load) begin
      shift_reg <= {u, shift_reg[K-2:1]};
      sym_valid <= 1'b1;
      sym       <= {par0, par1};
      sym_tail  <= tail_d;
      sym_last  <= last_d;
    end else if (sym_ready) begin
      sym_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_viterbi_conv_encoder.sv
// tb_viterbi_conv_encoder
//   Directed bench for viterbi_conv_encoder. Instance a uses the default code
//   with tail termination, instance b disables the tail. Expected symbols are
//   hand-derived for K=4, G0=17, G1=13 and stored as {tail, last, sym[1:0]}.
module tb_viterbi_conv_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_in_valid = 1'b0, a_in_bit = 1'b0, a_in_last = 1'b0, a_sym_ready = 1'b1;
  logic       a_in_ready, a_sym_valid, a_sym_tail, a_sym_last;
  logic [1:0] a_sym;

  logic       b_in_valid = 1'b0, b_in_bit = 1'b0, b_in_last = 1'b0, b_sym_ready = 1'b1;
  logic       b_in_ready, b_sym_valid, b_sym_tail, b_sym_last;
  logic [1:0] b_sym;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  logic [3:0] qa[$];
  logic [3:0] qb[$];

  viterbi_conv_encoder #(.TAIL_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bit(a_in_bit), .in_last(a_in_last),
    .sym_valid(a_sym_valid), .sym_ready(a_sym_ready), .sym(a_sym),
    .sym_tail(a_sym_tail), .sym_last(a_sym_last)
  );

  viterbi_conv_encoder #(.TAIL_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bit(b_in_bit), .in_last(b_in_last),
    .sym_valid(b_sym_valid), .sym_ready(b_sym_ready), .sym(b_sym),
    .sym_tail(b_sym_tail), .sym_last(b_sym_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Symbols are captured mid-cycle: a valid && ready pair seen at the
  // falling edge is consumed by the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_sym_valid && a_sym_ready) qa.push_back({a_sym_tail, a_sym_last, a_sym});
      if (b_sym_valid && b_sym_ready) qb.push_back({b_sym_tail, b_sym_last, b_sym});
    end
  end

  // Offers one bit and returns once it has been taken (#1 after the edge).
  task automatic send_bit(input bit sel, input logic bit_v, input logic last_v,
                          output int acc_cycle);
    int  waited = 0;
    bit  done = 0;
    logic rdy;
    acc_cycle = -1;
    if (sel) begin b_in_valid = 1'b1; b_in_bit = bit_v; b_in_last = last_v; end
    else     begin a_in_valid = 1'b1; a_in_bit = bit_v; a_in_last = last_v; end
    while (!done) begin
      @(negedge clk);
      rdy = sel ? b_in_ready : a_in_ready;
      if (rdy) begin
        acc_cycle = cycle;
        done = 1;
      end else begin
        waited++;
        if (waited > 40) begin
          total++; bad++;
          $display("[TB] FAIL send_timeout: in_ready got 0 want 1 after %0d cycles", waited);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    if (sel) begin b_in_valid = 1'b0; b_in_bit = 1'b0; b_in_last = 1'b0; end
    else     begin a_in_valid = 1'b0; a_in_bit = 1'b0; a_in_last = 1'b0; end
  endtask

  // Waits, bounded, until n symbols have been collected from instance sel.
  task automatic wait_syms(input bit sel, input int n);
    int waited = 0;
    while ((sel ? qb.size() : qa.size()) < n && waited < 60) begin
      @(posedge clk);
      waited++;
    end
    #1;
    if ((sel ? qb.size() : qa.size()) < n) begin
      total++; bad++;
      $display("[TB] FAIL wait_syms: got %0d symbols want %0d", sel ? qb.size() : qa.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (a_sym_valid !== 1'b0 || a_sym !== 2'b00 || a_sym_tail !== 1'b0 || a_sym_last !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got v=%b sym=%b t=%b l=%b want 0 00 0 0",
               a_sym_valid, a_sym, a_sym_tail, a_sym_last);
    end
    total++;
    if (a_in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", a_in_ready);
    end
    total++;
    if (b_sym_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_b_valid: got %b want 0", b_sym_valid);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_impulse();
    logic [3:0] exp_s[4] = '{4'b0011, 4'b1010, 4'b1011, 4'b1111};
    int acc;
    qa.delete();
    send_bit(1'b0, 1'b1, 1'b1, acc);
    total++;
    if (a_in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL impulse_tail_ready: got %b want 0", a_in_ready);
    end
    wait_syms(1'b0, 4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= qa.size() || qa[i] !== exp_s[i]) begin
        bad++;
        $display("[TB] FAIL impulse_sym%0d: got %b want %b", i,
                 (i < qa.size()) ? qa[i] : 4'bxxxx, exp_s[i]);
      end
    end
  endtask

  task automatic test_zero_frame();
    logic [3:0] want;
    int acc;
    qa.delete();
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0, (i == 7), acc);
    wait_syms(1'b0, 11);
    for (int i = 0; i < 11; i++) begin
      want = (i < 8) ? 4'b0000 : ((i == 10) ? 4'b1100 : 4'b1000);
      total++;
      if (i >= qa.size() || qa[i] !== want) begin
        bad++;
        $display("[TB] FAIL zero_sym%0d: got %b want %b", i,
                 (i < qa.size()) ? qa[i] : 4'bxxxx, want);
      end
    end
  endtask

  // Frame 1,0,1,1,0,0,1,0 + tail, derived by hand.
  task automatic test_pattern(input bit stall);
    logic       bits[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp_s[11] = '{4'b0011, 4'b0010, 4'b0000, 4'b0010, 4'b0001, 4'b0000,
                              4'b0000, 4'b0010, 4'b1011, 4'b1011, 4'b1100};
    logic [1:0] held;
    logic       held_t;
    int acc;
    qa.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) send_bit(1'b0, bits[i], (i == 7), acc);
      end
      begin
        if (stall) begin
          repeat (3) @(posedge clk);
          #1;
          a_sym_ready = 1'b0;
          held   = a_sym;
          held_t = a_sym_tail;
          for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (a_sym_valid !== 1'b1 || a_sym !== held || a_sym_tail !== held_t) begin
              bad++;
              $display("[TB] FAIL stall_hold%0d: got v=%b sym=%b want v=1 sym=%b",
                       c, a_sym_valid, a_sym, held);
            end
            total++;
            if (a_in_ready !== 1'b0) begin
              bad++;
              $display("[TB] FAIL stall_in_ready%0d: got %b want 0", c, a_in_ready);
            end
          end
          @(posedge clk);
          #1;
          a_sym_ready = 1'b1;
        end
      end
    join
    wait_syms(1'b0, 11);
    for (int i = 0; i < 11; i++) begin
      total++;
      if (i >= qa.size() || qa[i] !== exp_s[i]) begin
        bad++;
        $display("[TB] FAIL pattern%s_sym%0d: got %b want %b", stall ? "_stall" : "", i,
                 (i < qa.size()) ? qa[i] : 4'bxxxx, exp_s[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_s[4] = '{4'b0011, 4'b1010, 4'b1011, 4'b1111};
    int acc1, acc2;
    qa.delete();
    send_bit(1'b0, 1'b1, 1'b1, acc1);
    send_bit(1'b0, 1'b1, 1'b1, acc2);
    total++;
    if (acc2 - acc1 !== 4) begin
      bad++;
      $display("[TB] FAIL b2b_gap: got %0d cycles want 4", acc2 - acc1);
    end
    wait_syms(1'b0, 8);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= qa.size() || qa[i] !== exp_s[i % 4]) begin
        bad++;
        $display("[TB] FAIL b2b_sym%0d: got %b want %b", i,
                 (i < qa.size()) ? qa[i] : 4'bxxxx, exp_s[i % 4]);
      end
    end
  endtask

  // Frame 1,1 then frame 0 without tail; the 0 still sees state 110.
  task automatic test_no_tail();
    logic [3:0] exp_s[3] = '{4'b0011, 4'b0101, 4'b0101};
    int acc;
    qb.delete();
    send_bit(1'b1, 1'b1, 1'b0, acc);
    send_bit(1'b1, 1'b1, 1'b1, acc);
    send_bit(1'b1, 1'b0, 1'b1, acc);
    wait_syms(1'b1, 3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= qb.size() || qb[i] !== exp_s[i]) begin
        bad++;
        $display("[TB] FAIL notail_sym%0d: got %b want %b", i,
                 (i < qb.size()) ? qb[i] : 4'bxxxx, exp_s[i]);
      end
    end
  endtask

  task automatic test_reset_in_tail();
    int acc;
    send_bit(1'b0, 1'b1, 1'b1, acc);
    @(posedge clk);
    #2;
    total++;
    if (a_sym_valid !== 1'b1 || a_sym_tail !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_reset_tail: got v=%b t=%b want 1 1", a_sym_valid, a_sym_tail);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (a_sym_valid !== 1'b0 || a_sym_tail !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset: got v=%b t=%b want 0 0", a_sym_valid, a_sym_tail);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    qa.delete();
    @(posedge clk);
    #1;
    send_bit(1'b0, 1'b1, 1'b1, acc);
    wait_syms(1'b0, 4);
    total++;
    if (qa.size() < 1 || qa[0] !== 4'b0011) begin
      bad++;
      $display("[TB] FAIL post_reset_first: got %b want 0011",
               (qa.size() > 0) ? qa[0] : 4'bxxxx);
    end
    total++;
    if (qa.size() < 4 || qa[3] !== 4'b1111) begin
      bad++;
      $display("[TB] FAIL post_reset_last: got %b want 1111",
               (qa.size() > 3) ? qa[3] : 4'bxxxx);
    end
  endtask

  initial begin
    $display("[TB] viterbi_conv_encoder directed tests");
    test_reset();
    test_impulse();
    test_zero_frame();
    test_pattern(1'b0);
    test_pattern(1'b1);
    test_back_to_back();
    test_no_tail();
    test_reset_in_tail();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
